// File: rtl/unidade_controle.sv
// Sequencer for the multicycle processor: owns the step counter Tstep and
// decodes IR into the bus-select / register-enable lines of the datapath.
module unidade_controle (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       G_zero,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       DINout,
    output logic       Gout,
    output logic       Ain,
    output logic       Gin,
    output logic       AddSub,
    output logic       Done,
    output logic [1:0] Tstep
);

    typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    step_t      state, next_state;
    logic [2:0] opcode;
    logic [7:0] x_oh, y_oh;
    logic       is_alu;

    assign opcode = IR[8:6];
    assign x_oh   = 8'b1 << IR[5:3];
    assign y_oh   = 8'b1 << IR[2:0];
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign Tstep  = state;

    // Step register; reset drops straight back to fetch, aborting any instruction.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= T0;
        else         state <= next_state;
    end

    // Decode of the current step; Done always wins the next-state choice.
    always_comb begin
        next_state = state;
        IRin   = 1'b0;
        Rin    = '0;
        Rout   = '0;
        DINout = 1'b0;
        Gout   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        case (state)
            T0: begin
                IRin = Run;
                if (Run) next_state = T1;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        Rout = y_oh;
                        Rin  = x_oh;
                        Done = 1'b1;
                    end
                    OP_MVI: begin
                        DINout = 1'b1;
                        Rin    = x_oh;
                        Done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Rout = x_oh;
                        Ain  = 1'b1;
                    end
                    OP_MVNZ: begin
                        // G is not touched here, so G_zero reflects the last ALU result.
                        if (!G_zero) begin
                            Rout = y_oh;
                            Rin  = x_oh;
                        end
                        Done = 1'b1;
                    end
                    default: Done = 1'b1;
                endcase
                next_state = Done ? T0 : T2;
            end
            T2: begin
                if (is_alu) begin
                    Rout   = y_oh;
                    Gin    = 1'b1;
                    AddSub = (opcode == OP_SUB);
                    next_state = T3;
                end else begin
                    Done       = 1'b1;
                    next_state = T0;
                end
            end
            T3: begin
                // Only add/sub can legally get here; anything else just finishes.
                if (is_alu) begin
                    Gout = 1'b1;
                    Rin  = x_oh;
                end
                Done       = 1'b1;
                next_state = T0;
            end
            default: next_state = T0;
        endcase
        // Reset is combinational on the outputs too, so nothing fires while held.
        if (!Resetn) begin
            IRin   = 1'b0;
            Rin    = '0;
            Rout   = '0;
            DINout = 1'b0;
            Gout   = 1'b0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            AddSub = 1'b0;
            Done   = 1'b0;
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench: drives the sequencer next to a small behavioural datapath
// (R0..R7, A, G, IR) and checks enables and resulting register values.
module tb_unidade_controle;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic       G_zero;
    logic       IRin, DINout, Gout, Ain, Gin, AddSub, Done;
    logic [7:0] Rin, Rout;
    logic [1:0] Tstep;

    logic [15:0] DIN;
    logic [15:0] R [8];
    logic [15:0] A, G, bus;
    logic        dp_clr = 1'b0;
    logic        running = 1'b0;
    int          errors = 0;
    int          checks = 0;

    unidade_controle dut (
        .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR), .G_zero(G_zero),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .DINout(DINout), .Gout(Gout),
        .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .Tstep(Tstep)
    );

    always #5 Clock = ~Clock;

    assign G_zero = (G == 16'd0);

    // Shared bus of the datapath model
    always_comb begin
        bus = 16'd0;
        if (DINout) bus = DIN;
        else if (Gout) bus = G;
        else for (int i = 0; i < 8; i++) if (Rout[i]) bus = R[i];
    end

    // Datapath model: samples enables on the rising edge
    always @(posedge Clock or posedge dp_clr) begin
        if (dp_clr) begin
            R[0] <= 16'd11; R[1] <= 16'd10; R[2] <= 16'd9; R[3] <= 16'd0;
            R[4] <= 16'd7;  R[5] <= 16'd0;  R[6] <= 16'd0; R[7] <= 16'd0;
            A <= 16'd0; G <= 16'd0; IR <= 9'd0;
        end else begin
            if (IRin) IR <= DIN[8:0];
            for (int i = 0; i < 8; i++) if (Rin[i]) R[i] <= bus;
            if (Ain) A <= bus;
            if (Gin) G <= AddSub ? A - bus : A + bus;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bus exclusivity every cycle
    always @(negedge Clock) begin
        if (running) chk("bus_excl", 32'($countones({Rout, DINout, Gout}) <= 1), 32'd1);
    end

    function automatic logic [23:0] outs();
        return {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0; Run = 1'b1; DIN = 16'd0;
        #1 dp_clr = 1'b1;
        #1 dp_clr = 1'b0;
        running = 1'b1;
        #1 chk("rst_outs_run1", 32'(outs()), 32'd0);
        tick(); chk("rst_tstep", 32'(Tstep), 32'd0);

        // mv R0,R1
        Resetn = 1'b1; DIN = 16'b000_000_001; #1;
        chk("mv_t0_irin", 32'(IRin), 32'd1);
        chk("mv_t0_done", 32'(Done), 32'd0);
        tick(); #1;
        chk("mv_t1_rout", 32'(Rout), 32'h02);
        chk("mv_t1_rin", 32'(Rin), 32'h01);
        chk("mv_t1_done", 32'(Done), 32'd1);
        tick();
        chk("mv_r0", 32'(R[0]), 32'd10);
        chk("mv_back_t0", 32'(Tstep), 32'd0);

        // mvi R0,5
        DIN = 16'b001_000_001; #1;
        chk("mvi_t0_irin", 32'(IRin), 32'd1);
        tick(); DIN = 16'd5; #1;
        chk("mvi_t1_dinout", 32'(DINout), 32'd1);
        chk("mvi_t1_rin", 32'(Rin), 32'h01);
        chk("mvi_t1_done", 32'(Done), 32'd1);
        tick();
        chk("mvi_r0", 32'(R[0]), 32'd5);

        // sub R1,R0 : 10 - 5, Run dropped mid-instruction
        DIN = 16'b011_001_000; #1;
        tick(); #1;
        chk("sub_t1_rout", 32'(Rout), 32'h02);
        chk("sub_t1_ain", 32'(Ain), 32'd1);
        chk("sub_t1_done", 32'(Done), 32'd0);
        Run = 1'b0;
        tick(); #1;
        chk("sub_a", 32'(A), 32'd10);
        chk("sub_t2_tstep", 32'(Tstep), 32'd2);
        chk("sub_t2_rout", 32'(Rout), 32'h01);
        chk("sub_t2_gin", 32'(Gin), 32'd1);
        chk("sub_t2_addsub", 32'(AddSub), 32'd1);
        tick(); #1;
        chk("sub_g", 32'(G), 32'd5);
        chk("sub_t3_gout", 32'(Gout), 32'd1);
        chk("sub_t3_rin", 32'(Rin), 32'h02);
        chk("sub_t3_done", 32'(Done), 32'd1);
        chk("sub_t3_addsub", 32'(AddSub), 32'd0);
        tick();
        chk("sub_r1", 32'(R[1]), 32'd5);

        // Run low: hold in T0
        for (int i = 0; i < 3; i++) begin
            chk("idle_tstep", 32'(Tstep), 32'd0);
            chk("idle_outs", 32'(outs()), 32'd0);
            tick();
        end

        // mvnz R3,R1 with G=5
        Run = 1'b1; DIN = 16'b100_011_001; #1;
        chk("mvnz_t0_irin", 32'(IRin), 32'd1);
        tick(); #1;
        chk("mvnz_nz_rout", 32'(Rout), 32'h02);
        chk("mvnz_nz_rin", 32'(Rin), 32'h08);
        chk("mvnz_nz_done", 32'(Done), 32'd1);
        tick();
        chk("mvnz_nz_r3", 32'(R[3]), 32'd5);

        // sub R2,R2 -> 0, leaves G=0
        DIN = 16'b011_010_010; #1;
        tick(); #1; chk("subxx_t1_rout", 32'(Rout), 32'h04);
        tick(); #1; chk("subxx_t2_rout", 32'(Rout), 32'h04);
        tick(); #1; chk("subxx_t3_rin", 32'(Rin), 32'h04);
        tick();
        chk("subxx_r2", 32'(R[2]), 32'd0);
        chk("subxx_g", 32'(G), 32'd0);

        // mvnz R4,R1 with G=0: no move
        DIN = 16'b100_100_001; #1;
        tick(); #1;
        chk("mvnz_z_rinrout", 32'({Rin, Rout}), 32'd0);
        chk("mvnz_z_done", 32'(Done), 32'd1);
        tick();
        chk("mvnz_z_r4", 32'(R[4]), 32'd7);

        // add R5,R1 : 0 + 5
        DIN = 16'b010_101_001; #1;
        tick(); #1;
        chk("add_t1_rout", 32'(Rout), 32'h20);
        chk("add_t1_ain", 32'(Ain), 32'd1);
        tick(); #1;
        chk("add_t2_rout", 32'(Rout), 32'h02);
        chk("add_t2_addsub", 32'(AddSub), 32'd0);
        chk("add_t2_gin", 32'(Gin), 32'd1);
        tick(); #1;
        chk("add_t3_rin", 32'(Rin), 32'h20);
        chk("add_t3_done", 32'(Done), 32'd1);
        tick();
        chk("add_r5", 32'(R[5]), 32'd5);

        // reserved opcode 111
        DIN = 16'b111_010_011; #1;
        tick(); #1;
        chk("nop_t1_outs", 32'(outs()), 32'h000005);
        tick();
        chk("nop_back_t0", 32'(Tstep), 32'd0);

        // mv R3,R3
        DIN = 16'b000_011_011; #1;
        tick(); #1;
        chk("mvxx_rout", 32'(Rout), 32'h08);
        chk("mvxx_rin", 32'(Rin), 32'h08);
        tick();
        chk("mvxx_r3", 32'(R[3]), 32'd5);

        // sub R1,R0 aborted by reset in T2
        DIN = 16'b011_001_000; #1;
        tick(); tick();
        #2 Resetn = 1'b0;
        #1;
        chk("abort_tstep", 32'(Tstep), 32'd0);
        chk("abort_outs", 32'(outs()), 32'd0);
        tick();
        chk("abort_g", 32'(G), 32'd5);
        chk("abort_r1", 32'(R[1]), 32'd5);
        chk("abort_hold_outs", 32'(outs()), 32'd0);

        // Release with Run=1: fetch mv R6,R1 immediately
        DIN = 16'b000_110_001; Resetn = 1'b1; #1;
        chk("rel_irin", 32'(IRin), 32'd1);
        tick(); tick();
        chk("rel_r6", 32'(R[6]), 32'd5);

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
